// File: rtl/disk_mem_arbiter.sv
// disk_mem_arbiter: shares one byte-wide synchronous memory port between two
// requesters with sticky, burst-limited round-robin arbitration.
//   Grant is combinational from req and registered state (0-cycle latency).
//   Memory address/write strobe/write data are registered (1 cycle after grant).
//   Read data returns 2 cycles after the grant, tagged back to the issuing port.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   pN_req/wen/addr/wdata     requester N access (held until granted)
//   pN_gnt                    combinational grant; access accepted on req & gnt
//   pN_rvalid, p_rdata        read return strobe per port, shared read byte
//   mem_addr/wen/wdata        registered memory-side command
//   mem_rdata                 synchronous RAM output (valid 1 cycle after mem_addr)
//   owner, busy               last granted port, read in flight
module disk_mem_arbiter #(
  parameter int unsigned MAX_BURST = 512,
  parameter int unsigned ADDR_W    = 41
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0_req,
  input  logic              p0_wen,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [7:0]        p0_wdata,
  input  logic              p1_req,
  input  logic              p1_wen,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [7:0]        p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [7:0]        p_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              owner,
  output logic              busy
);

  localparam int unsigned    BCW  = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BMAX = BCW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST0 = 2'd1,
    BURST1 = 2'd2
  } state_t;

  state_t             state_q;
  logic               last_owner_q;
  logic [BCW-1:0]     bcnt_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_wen_q;
  logic [7:0]         mem_wdata_q;
  // Two-stage read tag pipe: stage 1 = memory address issued, stage 2 = data on mem_rdata.
  logic               tag1_vld_q, tag1_port_q;
  logic               tag2_vld_q, tag2_port_q;

  logic               grant_vld;
  logic               grant_port;
  logic               cur_port;
  logic               cur_req;
  logic               oth_req;
  state_t             grant_state;

  logic               sel_wen;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_wdata;

  // Grant decision. In a burst the current owner keeps the port unless the other
  // side is waiting and the owner has used up its burst allowance.
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    cur_port   = 1'b0;
    cur_req    = 1'b0;
    oth_req    = 1'b0;
    case (state_q)
      BURST0, BURST1: begin
        cur_port = (state_q == BURST1);
        cur_req  = cur_port ? p1_req : p0_req;
        oth_req  = cur_port ? p0_req : p1_req;
        if (cur_req && (!oth_req || (bcnt_q < BMAX))) begin
          grant_vld  = 1'b1;
          grant_port = cur_port;
        end else if (oth_req) begin
          grant_vld  = 1'b1;
          grant_port = ~cur_port;
        end
      end
      default: begin
        if (p0_req && p1_req) begin
          grant_vld  = 1'b1;
          grant_port = ~last_owner_q;
        end else if (p0_req || p1_req) begin
          grant_vld  = 1'b1;
          grant_port = p1_req;
        end
      end
    endcase
    // No grants while held in reset.
    grant_vld   = grant_vld & rstn;
    grant_state = grant_port ? BURST1 : BURST0;
  end

  assign p0_gnt = grant_vld & ~grant_port;
  assign p1_gnt = grant_vld &  grant_port;

  assign sel_wen   = grant_port ? p1_wen   : p0_wen;
  assign sel_addr  = grant_port ? p1_addr  : p0_addr;
  assign sel_wdata = grant_port ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      bcnt_q       <= '0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
      tag1_vld_q   <= 1'b0;
      tag1_port_q  <= 1'b0;
      tag2_vld_q   <= 1'b0;
      tag2_port_q  <= 1'b0;
    end else begin
      if (grant_vld) begin
        state_q      <= grant_state;
        last_owner_q <= grant_port;
        // Re-grant to the same owner extends the burst (saturating); a new owner starts at 1.
        if (state_q == grant_state) begin
          if (bcnt_q != BMAX) bcnt_q <= bcnt_q + BCW'(1);
        end else begin
          bcnt_q <= BCW'(1);
        end
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
        mem_wen_q   <= sel_wen;
      end else begin
        state_q   <= IDLE;
        bcnt_q    <= '0;
        mem_wen_q <= 1'b0;
      end
      tag1_vld_q  <= grant_vld & ~sel_wen;
      tag1_port_q <= grant_port;
      tag2_vld_q  <= tag1_vld_q;
      tag2_port_q <= tag1_port_q;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign p_rdata   = mem_rdata;
  assign p0_rvalid = tag2_vld_q & ~tag2_port_q;
  assign p1_rvalid = tag2_vld_q &  tag2_port_q;
  assign owner     = last_owner_q;
  assign busy      = tag1_vld_q | tag2_vld_q;

endmodule

// File: doc/disk_mem_arbiter.md
# disk_mem_arbiter

Shares one byte-wide synchronous disk memory port between two requesters, typically the USB mass-storage controller (port 0) and a local DMA/CPU client (port 1). The arbitration is sticky: the current owner keeps the port for bursts of up to MAX_BURST consecutive grants, then rotates if the other port is waiting. The memory-side signals are registered. Read data returns with a fixed, tagged latency.

## Interface
- MAX_BURST, 512: maximum consecutive grants to one port while the other port requests; legal range 1..65535.
- ADDR_W, 41: byte address width.
- clk  in  1  clock; the memory is sampled on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- p0_req, p1_req  in  1  access request, held until granted.
- p0_wen, p1_wen  in  1  1: write, 0: read; qualified by req.
- p0_addr, p1_addr  in  ADDR_W  byte address.
- p0_wdata, p1_wdata  in  8  write byte.
- p0_gnt, p1_gnt  out  1  combinational grant. The access is accepted in the cycle where req & gnt.
- p0_rvalid, p1_rvalid  out  1  read data valid for that port.
- p_rdata  out  8  shared read data; equals mem_rdata, passed through combinationally.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wen  out  1  registered write strobe.
- mem_wdata  out  8  registered write byte.
- mem_rdata  in  8  synchronous RAM output, valid one cycle after mem_addr.
- owner  out  1  last granted port (registered).
- busy  out  1  high while a granted read is still in the pipeline.

## Operation
- **FSM state** = {IDLE, BURST0, BURST1}.
  - BURSTn means port n was granted in the previous cycle.
  - last_owner is a register, reset value 1, so port 0 wins the first tie.
  - bcnt is the consecutive-grant counter, width clog2(MAX_BURST+1), and saturates at MAX_BURST.
- **IDLE:**
  - Only one port requests → grant it.
  - Both request → grant the port != last_owner.
  - Neither requests → no grant.
- **BURSTn:**
  - pn_req & (~pm_req | bcnt < MAX_BURST) → grant n again; bcnt++.
  - pn_req & pm_req & bcnt == MAX_BURST → grant m, go to BURSTm, bcnt=1.
  - ~pn_req & pm_req → grant m, bcnt=1.
  - Neither requests → IDLE, bcnt=0.
- **Grant bookkeeping:**
  - At most one gnt is high per cycle.
  - A grant to port x sets last_owner=x and the next state to BURSTx.
  - A cycle with no grant forces IDLE.
- **Memory side:** on the edge ending a granted cycle T:
  - mem_addr <= addr_x; mem_wdata <= wdata_x; mem_wen <= wen_x.
  - In cycles with no grant: mem_wen <= 0; mem_addr and mem_wdata hold their values.
- **Read return:**
  - A granted read at T loads a 2-stage tag pipe {valid, port}.
  - px_rvalid is high exactly in cycle T+2, when mem_rdata holds the byte for addr_x.
  - Writes produce no rvalid.
- **Ordering:** accesses reach memory strictly in grant order.
  - A write at T followed by a read of the same address at T+1 returns the new byte at T+3.
- **busy** = OR of the tag-pipe valid bits.

## Timing
- Reset values: mem_addr=0, mem_wen=0, mem_wdata=0, p0_rvalid=p1_rvalid=0, owner=1, busy=0, state=IDLE, bcnt=0.
- gnt is forced to 0 while rstn=0.
- Grant latency is 0 cycles (combinational from req and registered state).
- Memory address and write strobe appear 1 cycle after the grant. Read data appears 2 cycles after the grant.
- Throughput is one access per cycle, sustained, with no bubbles on owner switch.
- MAX_BURST=1 → strict alternation while both ports request.
- A single requester is never limited by MAX_BURST. bcnt saturates and does not wrap.
- Reset mid-operation:
  - The tag pipe is cleared, so in-flight reads never raise rvalid.
  - Any pending mem_wen is dropped.
- A requester that deasserts req in the same cycle it would be granted receives no grant, and no memory access occurs.

## Test plan
- **Tie after reset:** both req high from cycle 0, MAX_BURST=4 → p0_gnt for 4 cycles, then p1_gnt for 4, alternating in blocks of 4; owner tracks it.
- **Single requester:** p1 reads addr 0x10..0x1F continuously, memory preloaded with byte = addr → p1_rvalid high 2 cycles after each grant, with p_rdata 0x10..0x1F in order. No rotation occurs.
- **Write then read:** p0 writes 0xA5 to 0x1_0000_0200 at T and reads the same address at T+1 → mem_wen=1 at T+1; p0_rvalid at T+3 with p_rdata=0xA5.
- **Owner drops request:** p0 bursts 3 grants, drops req while p1 is requesting → p1_gnt in the next cycle, with no idle cycle between.
- **Reset mid-read:** p0 read granted at T, rstn low at T+1 → no p0_rvalid, all outputs at reset values, and the first grant after release goes to p0.
- **MAX_BURST=1 with both requests:** p0,p1,p0,p1… each granted 1 cycle. Each rvalid lands on the correct port, checked with interleaved addresses.
